perf_halt_monitor: RTL and testbench

PERF_HALT_MONITOR -- requirements
Module: perf_halt_monitor

---
 rtl/perf_halt_monitor.sv | 181 ++++++++++++++++++
 tb/tb_perf_halt_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_halt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : perf_halt_monitor
//  Description : Run/halt performance monitor. Counts cycles and retired
//                instructions while running, halts on a write to a trigger
//                address, and latches the first write seen on each of
//                NWATCH watched data-bus addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module perf_halt_monitor #(
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 32,
    parameter int                NWATCH    = 2,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}},
    parameter int                SAT_MODE  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clk_en,
    input  logic                     i_retire,
    input  logic [ADDR_W-1:0]        i_daddr,
    input  logic                     i_dwr,
    input  logic [DATA_W-1:0]        i_ddata,
    input  logic [NWATCH*ADDR_W-1:0] i_watch_addr,
    input  logic [NWATCH-1:0]        i_watch_en,
    input  logic                     i_cnt_clr,
    input  logic                     i_resume,
    output logic [CNT_W-1:0]         o_cycle_cnt,
    output logic [CNT_W-1:0]         o_instr_cnt,
    output logic                     o_halt,
    output logic                     o_sat,
    output logic [NWATCH-1:0]        o_watch_hit,
    output logic [NWATCH*DATA_W-1:0] o_watch_data
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               C_SAT     = (SAT_MODE != 0);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_halt;
    logic               w_run;
    logic               w_halt_evt;

    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_ins;
    logic [CNT_W-1:0]   w_cyc_nxt;
    logic [CNT_W-1:0]   w_ins_nxt;
    logic               w_cyc_ovf;
    logic               w_ins_ovf;
    logic               r_sat;
    logic               w_sat_nxt;

    assign w_run      = (r_state == ST_RUN);
    assign w_halt_evt = w_run && i_dwr && (i_daddr == HALT_ADDR);

    // ------------------------------------------------------------------
    // Run/halt state machine
    // ------------------------------------------------------------------

    // State register; the halt flag is registered alongside the state so
    // that o_halt comes straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_halt  <= 1'b0;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
            r_halt  <= (w_state_nxt == ST_HALTED);
        end
    end

    // Next-state logic: halt-address write stops, resume restarts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_halt_evt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

    // Next counter values; a clear beats any increment, and an increment
    // at all-ones either holds or wraps depending on SAT_MODE.
    always_comb begin
        w_cyc_nxt = r_cyc;
        w_ins_nxt = r_ins;
        w_cyc_ovf = 1'b0;
        w_ins_ovf = 1'b0;
        if (i_cnt_clr) begin
            w_cyc_nxt = '0;
            w_ins_nxt = '0;
        end else begin
            if (w_run) begin
                if (&r_cyc) begin
                    w_cyc_ovf = 1'b1;
                    w_cyc_nxt = C_SAT ? r_cyc : '0;
                end else begin
                    w_cyc_nxt = r_cyc + C_CNT_ONE;
                end
            end
            if (w_run && i_retire) begin
                if (&r_ins) begin
                    w_ins_ovf = 1'b1;
                    w_ins_nxt = C_SAT ? r_ins : '0;
                end else begin
                    w_ins_nxt = r_ins + C_CNT_ONE;
                end
            end
        end
        w_sat_nxt = i_cnt_clr ? 1'b0 : (r_sat | w_cyc_ovf | w_ins_ovf);
    end

    // Counter and sticky saturation flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc <= '0;
            r_ins <= '0;
            r_sat <= 1'b0;
        end else if (i_clk_en) begin
            r_cyc <= w_cyc_nxt;
            r_ins <= w_ins_nxt;
            r_sat <= w_sat_nxt;
        end
    end

    assign o_cycle_cnt = r_cyc;
    assign o_instr_cnt = r_ins;
    assign o_sat       = r_sat;
    assign o_halt      = r_halt;

    // ------------------------------------------------------------------
    // Write-watch channels: each latches the data of its first matching
    // write and then ignores further matches until reset. Capture runs in
    // both RUN and HALTED.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NWATCH; k++) begin : g_watch
        logic              r_hit;
        logic [DATA_W-1:0] r_data;
        logic              w_hit;

        assign w_hit = i_dwr && i_watch_en[k] && !r_hit &&
                       (i_daddr == i_watch_addr[k*ADDR_W +: ADDR_W]);

        // Sticky hit flag and first-write data capture for this channel.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_hit  <= 1'b0;
                r_data <= '0;
            end else if (i_clk_en && w_hit) begin
                r_hit  <= 1'b1;
                r_data <= i_ddata;
            end
        end

        assign o_watch_hit[k]                 = r_hit;
        assign o_watch_data[k*DATA_W +: DATA_W] = r_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_halt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_halt_monitor
//  Description : Self-checking bench for perf_halt_monitor. Three instances
//                (32-bit saturating, 4-bit saturating, 4-bit wrapping) share
//                one stimulus stream and are compared against an abstract
//                model every cycle, plus directed scenario checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_perf_halt_monitor;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int NWATCH = 2;
    localparam logic [ADDR_W-1:0] C_HALT = 24'hFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, clk_en, retire, dwr, cnt_clr, resume;
    logic [ADDR_W-1:0]        daddr;
    logic [DATA_W-1:0]        ddata;
    logic [NWATCH*ADDR_W-1:0] watch_addr;
    logic [NWATCH-1:0]        watch_en;

    logic [31:0] d0_cyc, d0_ins;
    logic [3:0]  d1_cyc, d1_ins, d2_cyc, d2_ins;
    logic        d0_halt, d1_halt, d2_halt, d0_sat, d1_sat, d2_sat;
    logic [1:0]  d0_hit, d1_hit, d2_hit;
    logic [63:0] d0_data, d1_data, d2_data;

    perf_halt_monitor #(.CNT_W(32), .SAT_MODE(1)) u_d0 (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_retire(retire),
        .i_daddr(daddr), .i_dwr(dwr), .i_ddata(ddata),
        .i_watch_addr(watch_addr), .i_watch_en(watch_en),
        .i_cnt_clr(cnt_clr), .i_resume(resume),
        .o_cycle_cnt(d0_cyc), .o_instr_cnt(d0_ins), .o_halt(d0_halt),
        .o_sat(d0_sat), .o_watch_hit(d0_hit), .o_watch_data(d0_data));

    perf_halt_monitor #(.CNT_W(4), .SAT_MODE(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_retire(retire),
        .i_daddr(daddr), .i_dwr(dwr), .i_ddata(ddata),
        .i_watch_addr(watch_addr), .i_watch_en(watch_en),
        .i_cnt_clr(cnt_clr), .i_resume(resume),
        .o_cycle_cnt(d1_cyc), .o_instr_cnt(d1_ins), .o_halt(d1_halt),
        .o_sat(d1_sat), .o_watch_hit(d1_hit), .o_watch_data(d1_data));

    perf_halt_monitor #(.CNT_W(4), .SAT_MODE(0)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_retire(retire),
        .i_daddr(daddr), .i_dwr(dwr), .i_ddata(ddata),
        .i_watch_addr(watch_addr), .i_watch_en(watch_en),
        .i_cnt_clr(cnt_clr), .i_resume(resume),
        .o_cycle_cnt(d2_cyc), .o_instr_cnt(d2_ins), .o_halt(d2_halt),
        .o_sat(d2_sat), .o_watch_hit(d2_hit), .o_watch_data(d2_data));

    // Reference model: unbounded event counts since last clear; each
    // instance's visible counter is derived from them arithmetically.
    longint      m_cyc, m_ins;
    bit          m_halted;
    bit [1:0]    m_hit;
    logic [31:0] m_data [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint exp_cnt(input longint n, input int w, input bit sat);
        longint lim;
        lim = longint'(1) << w;
        if (n < lim) return n;
        return sat ? (lim - 1) : (n % lim);
    endfunction

    function automatic bit exp_sat(input int w);
        longint lim;
        lim = longint'(1) << w;
        return (m_cyc >= lim) || (m_ins >= lim);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_cyc = 0; m_ins = 0; m_halted = 0; m_hit = 0;
            m_data[0] = 0; m_data[1] = 0;
        end else if (clk_en) begin
            for (int k = 0; k < NWATCH; k++) begin
                if (dwr && watch_en[k] && !m_hit[k] &&
                    daddr == watch_addr[k*ADDR_W +: ADDR_W]) begin
                    m_hit[k]  = 1'b1;
                    m_data[k] = ddata;
                end
            end
            if (cnt_clr) begin
                m_cyc = 0; m_ins = 0;
            end else if (!m_halted) begin
                m_cyc++;
                if (retire) m_ins++;
            end
            if (!m_halted) begin
                if (dwr && daddr == C_HALT) m_halted = 1'b1;
            end else if (resume) begin
                m_halted = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check("d0.cyc",  64'(d0_cyc),  64'(exp_cnt(m_cyc, 32, 1'b1)));
        check("d0.ins",  64'(d0_ins),  64'(exp_cnt(m_ins, 32, 1'b1)));
        check("d0.sat",  64'(d0_sat),  64'(exp_sat(32)));
        check("d1.cyc",  64'(d1_cyc),  64'(exp_cnt(m_cyc, 4, 1'b1)));
        check("d1.ins",  64'(d1_ins),  64'(exp_cnt(m_ins, 4, 1'b1)));
        check("d1.sat",  64'(d1_sat),  64'(exp_sat(4)));
        check("d2.cyc",  64'(d2_cyc),  64'(exp_cnt(m_cyc, 4, 1'b0)));
        check("d2.ins",  64'(d2_ins),  64'(exp_cnt(m_ins, 4, 1'b0)));
        check("d2.sat",  64'(d2_sat),  64'(exp_sat(4)));
        check("d0.halt", 64'(d0_halt), 64'(m_halted));
        check("d1.halt", 64'(d1_halt), 64'(m_halted));
        check("d2.halt", 64'(d2_halt), 64'(m_halted));
        check("d0.hit",  64'(d0_hit),  64'(m_hit));
        check("d2.hit",  64'(d2_hit),  64'(m_hit));
        check("d0.data", d0_data, {m_data[1], m_data[0]});
        check("d1.data", d1_data, {m_data[1], m_data[0]});
    endtask

    // One clock: inputs already applied, model follows the edge, outputs
    // sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; clk_en = 1; retire = 0; dwr = 0; daddr = '0; ddata = '0;
        cnt_clr = 0; resume = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; clk_en = 0;
        tick();
        idle();
    endtask

    initial begin
        watch_addr = {24'h000300, 24'h000100};
        watch_en   = 2'b00;
        idle();
        #2;

        // Reset state
        do_reset();
        check("rst.cyc",  64'(d0_cyc), 64'd0);
        check("rst.halt", 64'(d0_halt), 64'd0);
        check("rst.hit",  64'(d0_hit), 64'd0);

        // 10 cycles, retire on 6
        for (int i = 0; i < 10; i++) begin
            retire = ((i % 5) == 0) || ((i % 5) == 2) || ((i % 5) == 4);
            tick();
        end
        idle();
        check("run10.cyc",  64'(d0_cyc), 64'd10);
        check("run10.ins",  64'(d0_ins), 64'd6);
        check("run10.halt", 64'(d0_halt), 64'd0);

        // Halt write on cycle 5 with retire
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            retire = 1;
            dwr    = (i == 5);
            daddr  = (i == 5) ? C_HALT : 24'h000010;
            tick();
        end
        idle();
        check("halt.halt", 64'(d0_halt), 64'd1);
        check("halt.cyc",  64'(d0_cyc), 64'd5);
        check("halt.ins",  64'(d0_ins), 64'd5);
        for (int i = 0; i < 20; i++) begin
            retire = 1; dwr = (i == 7); daddr = C_HALT;
            tick();
        end
        idle();
        check("frozen.cyc",  64'(d0_cyc), 64'd5);
        check("frozen.ins",  64'(d0_ins), 64'd5);
        check("frozen.halt", 64'(d0_halt), 64'd1);

        // Resume then 3 cycles
        resume = 1;
        tick();
        idle();
        check("resume.halt", 64'(d0_halt), 64'd0);
        check("resume.cyc",  64'(d0_cyc), 64'd5);
        for (int i = 0; i < 3; i++) tick();
        check("resume3.cyc",  64'(d0_cyc), 64'd8);
        check("resume3.halt", 64'(d0_halt), 64'd0);

        // Reset with simultaneous halt write
        rst = 1; dwr = 1; daddr = C_HALT; retire = 1;
        tick();
        idle();
        check("rsthalt.halt", 64'(d0_halt), 64'd0);
        check("rsthalt.cyc",  64'(d0_cyc), 64'd0);
        check("rsthalt.ins",  64'(d0_ins), 64'd0);

        // Clock-enable gating, then clear beating retire
        do_reset();
        clk_en = 1; tick();
        clk_en = 0; tick();
        clk_en = 1; tick();
        clk_en = 0; tick();
        idle();
        check("clken.cyc", 64'(d0_cyc), 64'd2);
        cnt_clr = 1; retire = 1;
        tick();
        idle();
        check("clr.cyc", 64'(d0_cyc), 64'd0);
        check("clr.ins", 64'(d0_ins), 64'd0);

        // Watch channel 0 on 0x000100
        do_reset();
        watch_addr = {24'h000300, 24'h000100};
        watch_en   = 2'b11;
        dwr = 1; daddr = 24'h000100; ddata = 32'hDEADBEEF; tick();
        dwr = 1; daddr = 24'h000100; ddata = 32'h12345678; tick();
        idle();
        watch_en = 2'b00;
        tick();
        check("watch.hit",   64'(d0_hit), 64'b01);
        check("watch.data0", 64'(d0_data[31:0]), 64'hDEADBEEF);

        // 4-bit saturate vs wrap over 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        check("sat4.cyc",  64'(d1_cyc), 64'hF);
        check("sat4.sat",  64'(d1_sat), 64'd1);
        check("wrap4.cyc", 64'(d2_cyc), 64'd4);
        check("wrap4.sat", 64'(d2_sat), 64'd1);
        check("c32.sat",   64'(d0_sat), 64'd0);

        // Randomized phase
        for (int i = 0; i < 2000; i++) begin
            logic [ADDR_W-1:0] pool [4];
            pool[0] = 24'h000100; pool[1] = 24'h000200;
            pool[2] = 24'h000300; pool[3] = C_HALT;
            if ((i % 60) == 0) begin
                watch_addr = {pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]};
                watch_en   = 2'($urandom);
            end
            rst     = ($urandom_range(0, 149) == 0);
            clk_en  = ($urandom_range(0, 3) != 0);
            retire  = $urandom_range(0, 1) == 1;
            dwr     = ($urandom_range(0, 2) == 0);
            daddr   = ($urandom_range(0, 4) == 0) ? 24'($urandom) : pool[$urandom_range(0, 3)];
            ddata   = $urandom;
            cnt_clr = ($urandom_range(0, 39) == 0);
            resume  = ($urandom_range(0, 5) == 0);
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
